store_buffer: RTL

// - In-order FIFO of committed stores. Sits in the MEM stage between the pipeline and the dcache write port.
// - MEM pushes retiring stores (mem_sb_put_enable); the head drains to the dcache (mem_sb_get_enable).
// - Loads snoop it combinationally (mem_use_sb_snoop_data) for store-to-load forwarding.

---
 rtl/store_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// In-order store buffer between MEM and the dcache write port, with same-cycle
// store-to-load forwarding snoop. Define STORE_BUFFER_COALESCE_EN to merge same-word pushes.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  put_enable_i,
    input  logic [ADDR_WIDTH-1:0] put_addr_i,
    input  logic [DATA_WIDTH-1:0] put_data_i,
    input  logic [1:0]            put_size_i,
    input  logic                  get_enable_i,
    output logic [ADDR_WIDTH-1:0] head_addr_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [3:0]            head_be_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [ADDR_WIDTH-1:0] snoop_addr_i,
    input  logic [1:0]            snoop_size_i,
    output logic                  snoop_hit_o,
    output logic                  snoop_partial_o,
    output logic [DATA_WIDTH-1:0] snoop_data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef struct packed {
        logic [ADDR_WIDTH-3:0] waddr;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    function automatic logic [3:0] be_of(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            SZ_BYTE: be_of = 4'b0001 << lo;
            SZ_HALF: be_of = 4'b0011 << {lo[1], 1'b0};
            default: be_of = 4'b1111;
        endcase
    endfunction

    // Replicate narrow data across lanes so whichever lanes are enabled carry it.
    function automatic logic [DATA_WIDTH-1:0] align(input logic [DATA_WIDTH-1:0] d, input logic [1:0] size);
        case (size)
            SZ_BYTE: align = {4{d[7:0]}};
            SZ_HALF: align = {2{d[15:0]}};
            default: align = d;
        endcase
    endfunction

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, count_next;
    logic            full_q, empty_q;

    logic [3:0]            put_be, load_be;
    logic [DATA_WIDTH-1:0] put_word;
    logic                  pop, alloc, merge;

    assign put_be   = be_of(put_addr_i[1:0], put_size_i);
    assign put_word = align(put_data_i, put_size_i);
    assign load_be  = be_of(snoop_addr_i[1:0], snoop_size_i);
    assign pop      = get_enable_i && !empty_q;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail - PW'(1);
    // A single entry that is leaving this cycle cannot absorb the new store.
    assign merge = put_enable_i && !empty_q
                && mem[youngest].waddr == put_addr_i[ADDR_WIDTH-1:2]
                && !(pop && youngest == head);
`else
    assign merge = 1'b0;
`endif

    assign alloc      = put_enable_i && !merge && (!full_q || pop);
    assign count_next = count + CW'(alloc) - CW'(pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            // After the pop so a full push+pop into the same slot leaves it valid.
            if (alloc) begin
                mem[tail]   <= '{waddr: put_addr_i[ADDR_WIDTH-1:2], be: put_be, data: put_word};
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (merge) begin
                mem[youngest].be <= mem[youngest].be | put_be;
                for (int b = 0; b < 4; b++)
                    if (put_be[b]) mem[youngest].data[8*b +: 8] <= put_word[8*b +: 8];
            end
`endif
            count   <= count_next;
            full_q  <= (count_next == CW'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign head_addr_o = valid[head] ? {mem[head].waddr, 2'b00} : '0;
    assign head_be_o   = valid[head] ? mem[head].be : 4'b0000;
    assign head_data_o = valid[head] ? mem[head].data : '0;

    // Walk back from the youngest entry; first overlap decides hit vs partial.
    logic          found;
    logic [PW-1:0] sel, idx;
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(i + 1);
            if (!found && valid[idx] && mem[idx].waddr == snoop_addr_i[ADDR_WIDTH-1:2]
                && (mem[idx].be & load_be) != 4'b0000) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign snoop_hit_o     = found && ((mem[sel].be & load_be) == load_be);
    assign snoop_partial_o = found && !snoop_hit_o;
    assign snoop_data_o    = snoop_hit_o ? mem[sel].data : '0;
endmodule
